// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the multi-read-port register file.
//   RF_DATA_W / RF_ADDR_W / RF_NUM_RD : default data width, address width, read port count
//   ZERO_REG                          : address of the hardwired-zero register
//   slice_lo()                        : low bit index of element idx in a flattened bus
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;
    localparam int RF_NUM_RD = 2;

    localparam int ZERO_REG  = 0;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_mp_if.sv
// rf_mp_if: issue/writeback bus of the register file.
//   rd_en[NUM_RD], rd_addr[NUM_RD*ADDR_W] : read requests from issue
//   rd_data[NUM_RD*DATA_W], rd_busy[NUM_RD] : operand data and pending flag per port
//   we, wr_addr, wr_data                  : writeback
//   alloc_en, alloc_addr                  : destination allocation from issue
//   hlt                                   : freezes all state updates and bypass
// master = issue/writeback side, slave = register file.
interface rf_mp_if import rf_pkg::*; #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
);

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic                     hlt;

    modport master (
        output rd_en, rd_addr, we, wr_addr, wr_data, alloc_en, alloc_addr, hlt,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_en, rd_addr, we, wr_addr, wr_data, alloc_en, alloc_addr, hlt,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/rf_rd_port.sv
// rf_rd_port: one combinational read port of the register file.
//   en, addr        : read request
//   mem, pend       : stored register array and pending vector
//   wr_vld          : a write is committing this cycle (non-zero address, not halted, not in reset)
//   wr_addr/wr_data : the committing write, forwarded when addresses match
//   data, busy      : operand value and pending flag
module rf_rd_port import rf_pkg::*; #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                                en,
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]    mem,
    input  logic [2**ADDR_W-1:0]                pend,
    input  logic                                wr_vld,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [DATA_W-1:0]                   wr_data,
    output logic [DATA_W-1:0]                   data,
    output logic                                busy
);

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (en) begin
            // The write being retired this cycle is the freshest value and
            // also resolves the hazard, so busy stays low on a bypass hit.
            if (wr_vld && (addr == wr_addr)) begin
                data = wr_data;
            end else if (addr != ADDR_W'(ZERO_REG)) begin
                data = mem[addr];
                busy = pend[addr];
            end
        end
    end

endmodule

// File: rtl/rf_mp.sv
// rf_mp: multi-read-port register file with write-through bypass, hardwired
// zero register and a per-register pending scoreboard.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears data and pending bits
//   bus   : rf_mp_if slave (read ports, writeback, alloc, halt)
module rf_mp import rf_pkg::*; #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
) (
    input  logic    clk,
    input  logic    rst_n,
    rf_mp_if.slave  bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             pend;

    logic wr_ok;
    logic alloc_ok;
    logic wr_vld;

    assign wr_ok    = bus.we && !bus.hlt && (bus.wr_addr != ADDR_W'(ZERO_REG));
    assign alloc_ok = bus.alloc_en && !bus.hlt && (bus.alloc_addr != ADDR_W'(ZERO_REG));
    // While reset is held the ports must show the cleared array, so the
    // bypass path is suppressed as well.
    assign wr_vld   = wr_ok && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            pend <= '0;
        end else begin
            if (wr_ok) begin
                mem[bus.wr_addr]  <= bus.wr_data;
                pend[bus.wr_addr] <= 1'b0;
            end
            // Placed after the write so a same-address alloc leaves the
            // register pending: the newly issued producer owns it.
            if (alloc_ok) begin
                pend[bus.alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        localparam int A_LO = slice_lo(i, ADDR_W);
        localparam int D_LO = slice_lo(i, DATA_W);

        rf_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .en      (bus.rd_en[i]),
            .addr    (bus.rd_addr[A_LO +: ADDR_W]),
            .mem     (mem),
            .pend    (pend),
            .wr_vld  (wr_vld),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .data    (bus.rd_data[D_LO +: DATA_W]),
            .busy    (bus.rd_busy[i])
        );
    end

endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed bench for rf_mp with a four-port instance. A register
// array / pending array model predicts every port each cycle; literal
// expectations pin the key scenarios.
module tb_rf_mp;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NR    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    rf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Architectural state as seen after each edge.
    logic [DW-1:0] mdl_mem  [DEPTH];
    logic          mdl_pend [DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mdl_mem[r]  <= '0;
                mdl_pend[r] <= 1'b0;
            end
        end else if (!bus.hlt) begin
            if (bus.we && bus.wr_addr != 0) begin
                mdl_mem[bus.wr_addr]  <= bus.wr_data;
                mdl_pend[bus.wr_addr] <= 1'b0;
            end
            if (bus.alloc_en && bus.alloc_addr != 0)
                mdl_pend[bus.alloc_addr] <= 1'b1;
        end
    end

    // Expected {busy, data} of port p given the current inputs.
    function automatic logic [DW:0] expect_port(input int p);
        int a;
        a = int'(bus.rd_addr[p*AW +: AW]);
        if (!bus.rd_en[p] || !rst_n || a == 0)
            return '0;
        if (!bus.hlt && bus.we && int'(bus.wr_addr) == a)
            return {1'b0, bus.wr_data};
        return {mdl_pend[a], mdl_mem[a]};
    endfunction

    function automatic logic [DW:0] port_out(input int p);
        return {bus.rd_busy[p], bus.rd_data[p*DW +: DW]};
    endfunction

    always @(negedge clk) begin : compare
        logic [DW:0] e;
        if (chk_on) begin
            for (int p = 0; p < NR; p++) begin
                e = expect_port(p);
                total++;
                if (bus.rd_data[p*DW +: DW] !== e[DW-1:0]) begin
                    bad++;
                    $display("FAIL model_data p%0d got=%h want=%h t=%0t",
                             p, bus.rd_data[p*DW +: DW], e[DW-1:0], $time);
                end
                total++;
                if (bus.rd_busy[p] !== e[DW]) begin
                    bad++;
                    $display("FAIL model_busy p%0d got=%b want=%b t=%0t",
                             p, bus.rd_busy[p], e[DW], $time);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [DW:0] got, input logic [DW:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got busy=%b data=%h want busy=%b data=%h",
                     nm, got[DW], got[DW-1:0], want[DW], want[DW-1:0]);
        end
    endtask

    task automatic rd(input int p, input logic en, input int a);
        bus.rd_en[p]            = en;
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        bus.rd_en      = '0;
        bus.rd_addr    = '0;
        bus.we         = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.alloc_en   = 1'b0;
        bus.alloc_addr = '0;
        bus.hlt        = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        bus.we      = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
    endtask

    task automatic alloc(input int a);
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = AW'(a);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    int          tbl_a [4] = '{1, 2, 10, 15};
    logic [15:0] tbl_d [4] = '{16'h0101, 16'hA0A0, 16'h7FFF, 16'h8001};

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk_on = 1'b1;

        // Out of reset: everything reads zero.
        rst_n = 1'b1;
        rd(0, 1, 5);
        probe();
        lit("reset_r5", port_out(0), 17'h00000);
        tick();

        // R5 = 0x1234, then an async reset with a write in flight.
        wr(5, 16'h1234);
        rd(2, 1, 5);
        probe();
        lit("r5_bypass", port_out(2), 17'h01234);
        tick();
        bus.we = 1'b0;
        probe();
        lit("r5_stored", port_out(2), 17'h01234);
        tick();
        rst_n = 1'b0;
        for (int p = 0; p < 3; p++) rd(p, 1, 5);
        rd(3, 1, 6);
        wr(6, 16'h7777);
        probe();
        for (int p = 0; p < 3; p++) lit($sformatf("rst_r5_p%0d", p), port_out(p), 17'h00000);
        lit("rst_no_bypass", port_out(3), 17'h00000);
        tick();
        rst_n = 1'b1;
        bus.we = 1'b0;
        probe();
        lit("rst_r5_after", port_out(0), 17'h00000);
        lit("rst_r6_discarded", port_out(3), 17'h00000);
        tick();

        // Write-through bypass on R3.
        idle();
        wr(3, 16'hBEEF);
        rd(0, 1, 3);
        probe();
        lit("r3_bypass", port_out(0), 17'h0BEEF);
        tick();
        bus.we = 1'b0;
        probe();
        lit("r3_stored", port_out(0), 17'h0BEEF);
        tick();

        // Hardwired zero register.
        idle();
        wr(0, 16'hFFFF);
        rd(0, 1, 0);
        rd(1, 1, 0);
        probe();
        lit("r0_no_bypass", port_out(0), 17'h00000);
        tick();
        bus.we = 1'b0;
        alloc(0);
        probe();
        lit("r0_after_write", port_out(0), 17'h00000);
        tick();
        bus.alloc_en = 1'b0;
        probe();
        lit("r0_after_alloc", port_out(1), 17'h00000);
        tick();

        // Scoreboard on R7.
        idle();
        alloc(7);
        rd(1, 1, 7);
        probe();
        lit("r7_alloc_same_cycle", port_out(1), 17'h00000);
        tick();
        bus.alloc_en = 1'b0;
        probe();
        lit("r7_busy", port_out(1), 17'h10000);
        tick();
        wr(7, 16'h00A5);
        probe();
        lit("r7_wb_bypass", port_out(1), 17'h000A5);
        tick();
        bus.we = 1'b0;
        probe();
        lit("r7_clear_stored", port_out(1), 17'h000A5);
        tick();

        // Simultaneous alloc and write on R9: new producer wins.
        idle();
        wr(9, 16'h0042);
        alloc(9);
        rd(1, 1, 9);
        probe();
        lit("r9_bypass", port_out(1), 17'h00042);
        tick();
        bus.we = 1'b0;
        bus.alloc_en = 1'b0;
        probe();
        lit("r9_busy_data", port_out(1), 17'h10042);
        tick();
        wr(9, 16'h0043);
        probe();
        lit("r9_wb", port_out(1), 17'h00043);
        tick();
        bus.we = 1'b0;
        probe();
        lit("r9_clear", port_out(1), 17'h00043);
        tick();

        // Halt: no bypass, no write, no alloc; reads continue.
        idle();
        bus.hlt = 1'b1;
        wr(4, 16'h5555);
        alloc(8);
        for (int p = 0; p < NR; p++) rd(p, 1, 4);
        probe();
        for (int p = 0; p < NR; p++) lit($sformatf("hlt_r4_p%0d", p), port_out(p), 17'h00000);
        tick();
        rd(0, 1, 3);
        probe();
        lit("hlt_r3_read", port_out(0), 17'h0BEEF);
        tick();
        bus.hlt = 1'b0;
        bus.we = 1'b0;
        bus.alloc_en = 1'b0;
        rd(0, 1, 8);
        probe();
        lit("hlt_r8_not_pend", port_out(0), 17'h00000);
        for (int p = 1; p < NR; p++) lit($sformatf("hlt_r4_kept_p%0d", p), port_out(p), 17'h00000);
        tick();

        // All ports on one register, and a disabled port during bypass.
        idle();
        for (int p = 0; p < NR; p++) rd(p, 1, 3);
        probe();
        for (int p = 0; p < NR; p++) lit($sformatf("same_r3_p%0d", p), port_out(p), 17'h0BEEF);
        tick();
        rd(0, 0, 3);
        wr(3, 16'h1111);
        probe();
        lit("en0_disabled", port_out(0), 17'h00000);
        lit("en1_bypass", port_out(1), 17'h01111);
        tick();

        // Distinct addresses on every port.
        idle();
        for (int i = 0; i < 4; i++) begin
            wr(tbl_a[i], tbl_d[i]);
            tick();
        end
        bus.we = 1'b0;
        for (int p = 0; p < NR; p++) rd(p, 1, tbl_a[p]);
        probe();
        for (int p = 0; p < NR; p++)
            lit($sformatf("table_p%0d", p), port_out(p), {1'b0, tbl_d[p]});
        tick();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
